// File: rtl/elevator_scan_controller.sv
// SCAN elevator controller: latches floor requests into a pending bitmap and serves them
// in the current travel direction while requests remain ahead, with per-floor travel
// pacing and a door-open hold at every served floor.
module elevator_scan_controller #(
  parameter int unsigned NUM_FLOORS    = 10,
  parameter int unsigned FLOOR_W       = 4,
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [1:0]            state,
  output logic                  door_open,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam logic [1:0] StIdle     = 2'b00;
  localparam logic [1:0] StDoorOpen = 2'b01;
  localparam logic [1:0] StMoveUp   = 2'b10;
  localparam logic [1:0] StMoveDown = 2'b11;

  localparam int unsigned TravelW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DoorW   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TravelW-1:0] TravelLast = TravelW'(TRAVEL_CYCLES - 1);
  localparam logic [DoorW-1:0]   DoorLast   = DoorW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TopFloor   = FLOOR_W'(NUM_FLOORS - 1);

  logic [1:0]            state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TravelW-1:0]    travel_q, travel_d;
  logic [DoorW-1:0]      door_q, door_d;

  logic                  above, below, above_next, below_next;
  logic                  here_hit, up_hit, dn_hit;
  logic                  serve;
  logic [FLOOR_W-1:0]    serve_floor;
  logic                  absorb;

  // Request-position summary relative to the current floor and its two neighbours.
  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    above_next = 1'b0;
    below_next = 1'b0;
    here_hit   = 1'b0;
    up_hit     = 1'b0;
    dn_hit     = 1'b0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending_q[i]) begin
        if (i > int'(floor_q))     above      = 1'b1;
        if (i < int'(floor_q))     below      = 1'b1;
        if (i > int'(floor_q) + 1) above_next = 1'b1;
        if (i < int'(floor_q) - 1) below_next = 1'b1;
        if (i == int'(floor_q))     here_hit  = 1'b1;
        if (i == int'(floor_q) + 1) up_hit    = 1'b1;
        if (i == int'(floor_q) - 1) dn_hit    = 1'b1;
      end
    end
  end

  // Next-state logic for the FSM, car position, direction and counters.
  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    dir_up_d    = dir_up_q;
    travel_d    = travel_q;
    door_d      = door_q;
    serve       = 1'b0;
    serve_floor = floor_q;
    case (state_q)
      StIdle: begin
        if (here_hit) begin
          state_d = StDoorOpen;
          serve   = 1'b1;
          door_d  = '0;
        end else if ((dir_up_q && above) || (above && !below)) begin
          state_d  = StMoveUp;
          dir_up_d = 1'b1;
          travel_d = '0;
        end else if (below) begin
          state_d  = StMoveDown;
          dir_up_d = 1'b0;
          travel_d = '0;
        end
      end
      StMoveUp: begin
        if (travel_q == TravelLast) begin
          travel_d = '0;
          if (floor_q != TopFloor) floor_d = floor_q + 1'b1;
          if (up_hit) begin
            state_d     = StDoorOpen;
            serve       = 1'b1;
            serve_floor = floor_q + 1'b1;
            door_d      = '0;
          end else if (!above_next) begin
            state_d = StIdle;
          end
        end else begin
          travel_d = travel_q + 1'b1;
        end
      end
      StMoveDown: begin
        if (travel_q == TravelLast) begin
          travel_d = '0;
          if (floor_q != '0) floor_d = floor_q - 1'b1;
          if (dn_hit) begin
            state_d     = StDoorOpen;
            serve       = 1'b1;
            serve_floor = floor_q - 1'b1;
            door_d      = '0;
          end else if (!below_next) begin
            state_d = StIdle;
          end
        end else begin
          travel_d = travel_q + 1'b1;
        end
      end
      StDoorOpen: begin
        // A fresh call for this floor keeps the door open for another full interval.
        if (req_valid && (req_floor == floor_q)) begin
          door_d = '0;
        end else if (door_q == DoorLast) begin
          state_d = StIdle;
          door_d  = '0;
        end else begin
          door_d = door_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending bitmap: set from requests, then clear the served floor so a same-edge
  // request for that floor is absorbed.
  always_comb begin
    absorb    = (state_q == StDoorOpen) && (req_floor == floor_q);
    pending_d = pending_q;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (req_valid && !absorb && (int'(req_floor) == i)) pending_d[i] = 1'b1;
      if (serve && (int'(serve_floor) == i))              pending_d[i] = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      floor_q   <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      travel_q  <= '0;
      door_q    <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      travel_q  <= travel_d;
      door_q    <= door_d;
    end
  end

  assign current_floor = floor_q;
  assign state         = state_q;
  assign door_open     = (state_q == StDoorOpen);
  assign dir_up        = dir_up_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: directed scenarios with cycle checks plus a
// scoreboard of expected service floors, popped whenever the door opens.
module tb_elevator_scan_controller;

  localparam int unsigned NF = 10;
  localparam int unsigned FW = 4;
  localparam int unsigned TC = 4;
  localparam int unsigned DC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic [FW-1:0] current_floor;
  logic [1:0]    state;
  logic          door_open;
  logic          dir_up;
  logic [NF-1:0] pending;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_q[$];
  logic        door_prev = 1'b0;

  elevator_scan_controller #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES  (DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .current_floor(current_floor),
    .state        (state),
    .door_open    (door_open),
    .dir_up       (dir_up),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int f);
    req_valid = 1'b1;
    req_floor = f[FW-1:0];
    step();
    req_valid = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned max_cyc);
    int unsigned k = 0;
    while (k < max_cyc && !(state == 2'b00 && pending == '0)) begin
      step();
      k++;
    end
    check(tag, (state == 2'b00 && pending == '0), 1);
  endtask

  // Scoreboard: each rising door_open must match the next expected service floor.
  always @(negedge clk) begin
    if (reset) begin
      door_prev <= 1'b0;
    end else begin
      if (door_open && !door_prev) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("door_floor", current_floor, exp_q.pop_front());
      end
      door_prev <= door_open;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int door7;
    int fall;
    int k;
    int unsigned max_f;
    int unsigned open_cyc;

    // Reset while a request is presented: nothing latches.
    reset     = 1'b1;
    req_valid = 1'b1;
    req_floor = 4'd5;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_floor", current_floor, 0);
      check("rst_state", state, 0);
      check("rst_pend", pending, 0);
      check("rst_dir", dir_up, 1);
      check("rst_door", door_open, 0);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    step();
    check("rst_nolatch", pending, 0);
    check("rst_idle", state, 0);

    // Single request for floor 3, cycle-exact.
    exp_q.push_back(3);
    send(3);
    check("s1_pend_e0", pending, 10'h008);
    check("s1_state_e0", state, 0);
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 1)  check("s1_moveup_e1", state, 2);
      if (e == 4)  check("s1_f0_e4", current_floor, 0);
      if (e == 5)  check("s1_f1_e5", current_floor, 1);
      if (e == 9)  check("s1_f2_e9", current_floor, 2);
      if (e == 12) check("s1_door_e12", door_open, 0);
      if (e == 13) check("s1_f3_e13", current_floor, 3);
      if (e == 13) check("s1_door_e13", door_open, 1);
      if (e == 15) check("s1_door_e15", door_open, 1);
      if (e == 16) check("s1_idle_e16", state, 0);
      if (e == 16) check("s1_pend_e16", pending, 0);
    end

    // SCAN order: 5, then 1 and 7 requested while passing floor 2.
    reset_dut();
    send(5);
    exp_q.push_back(5);
    k = 0;
    while (k < 100 && current_floor != 2) begin
      step();
      k++;
    end
    check("scan_at2", current_floor, 2);
    exp_q.push_back(7);
    exp_q.push_back(1);
    send(1);
    send(7);
    check("scan_pass2", current_floor, 2);
    check("scan_pend", pending, 10'h0A2);
    door7 = -1;
    fall  = -1;
    k     = 0;
    while (k < 300 && !(state == 2'b00 && pending == '0)) begin
      step();
      if (door_open && current_floor == 7 && door7 < 0) door7 = k;
      if (!dir_up && fall < 0) fall = k;
      k++;
    end
    check("scan_done", (state == 2'b00 && pending == '0), 1);
    check("scan_fall_after7", (door7 >= 0 && fall > door7), 1);
    check("scan_end_floor", current_floor, 1);

    // Door extension at floor 3.
    reset_dut();
    exp_q.push_back(3);
    send(3);
    k = 0;
    while (k < 100 && !door_open) begin
      step();
      k++;
    end
    check("dx_open", door_open, 1);
    open_cyc  = 1;
    req_valid = 1'b1;
    req_floor = 4'd3;
    step();
    req_valid = 1'b0;
    k = 0;
    while (k < 20 && door_open) begin
      open_cyc++;
      check("dx_pend3", pending[3], 0);
      step();
      k++;
    end
    check("dx_len", open_cyc, 4);
    check("dx_idle", state, 0);

    // Boundaries: out-of-range drop, top and bottom floors.
    reset_dut();
    send(12);
    check("bnd_drop", pending, 0);
    step();
    check("bnd_stay_idle", state, 0);
    exp_q.push_back(9);
    send(9);
    max_f = 0;
    k = 0;
    while (k < 200 && !(state == 2'b00 && pending == '0)) begin
      step();
      if (current_floor > max_f) max_f = current_floor;
      k++;
    end
    check("bnd_top", current_floor, 9);
    exp_q.push_back(0);
    send(0);
    k = 0;
    while (k < 200 && !(state == 2'b00 && pending == '0)) begin
      step();
      if (current_floor > max_f) max_f = current_floor;
      k++;
    end
    check("bnd_bottom", current_floor, 0);
    check("bnd_max", max_f, 9);
    wait_idle("bnd_idle", 10);

    // Reset mid-move between floors 4 and 5 with {5,8} pending.
    reset_dut();
    send(5);
    send(8);
    k = 0;
    while (k < 100 && !(current_floor == 4 && state == 2'b10)) begin
      step();
      k++;
    end
    step();
    check("mm_floor4", current_floor, 4);
    check("mm_pend", pending, 10'h120);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mm_floor", current_floor, 0);
    check("mm_state", state, 0);
    check("mm_pend0", pending, 0);
    check("mm_dir", dir_up, 1);
    step();
    check("mm_stay", state, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_scan_controller.md
# elevator_scan_controller

Parametrised multi-request elevator controller for an N-floor car. It latches floor requests into a pending bitmap and serves them in SCAN order, continuing in the current direction while requests remain ahead. Arrivals are paced by a per-floor travel timer, and each served floor is held with a door-open interval. `current_floor` drives the existing `segment7` floor display; `pending` drives request indicator LEDs.

## Interface
- `NUM_FLOORS`, default 10: number of floors, 2..2^FLOOR_W; floors are numbered 0..NUM_FLOORS-1.
- `FLOOR_W`, default 4: width of the floor index.
- `TRAVEL_CYCLES`, default 16: clock cycles per one-floor move; must be ≥1.
- `DOOR_CYCLES`, default 8: clock cycles the door stays open; must be ≥1.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request strobe, sampled every edge.
- `req_floor`  in  FLOOR_W  requested floor; qualified by `req_valid`.
- `current_floor`  out  FLOOR_W  registered car position.
- `state`  out  2  IDLE=00, DOOR_OPEN=01, MOVE_UP=10, MOVE_DOWN=11.
- `door_open`  out  1  high iff `state`==DOOR_OPEN.
- `dir_up`  out  1  last/preferred travel direction; 1 means up.
- `pending`  out  NUM_FLOORS  latched unserved requests, one bit per floor.

## Operation
- Reset (synchronous, active-high) sets `current_floor`=0, `state`=IDLE, `door_open`=0, `dir_up`=1, `pending`=0, and both internal counters to 0. Reset overrides everything. `req_valid` is ignored while `reset`=1. A reset mid-move discards all requests and returns the car to floor 0 immediately; there is no travel back.
- Request capture: when `req_valid`=1 and `req_floor` < NUM_FLOORS, set `pending[req_floor]`. Out-of-range floors are silently dropped. A request for the floor being served on the same edge is absorbed and never sets its bit (see DOOR_OPEN and arrival below).
- "above" = any `pending` bit > `current_floor`; "below" = any bit < `current_floor`.
- IDLE:
  - If `pending[current_floor]` is set: go to DOOR_OPEN, clear the bit, and zero the door counter.
  - Else if (`dir_up` and above) or (above and not below): go to MOVE_UP and set `dir_up`=1.
  - Else if below: go to MOVE_DOWN and set `dir_up`=0.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - The travel counter increments each cycle.
  - At count TRAVEL_CYCLES-1: `current_floor` goes ±1, the counter returns to 0, and the arrival check runs against the new floor value nf:
    - If `pending[nf]` is set: go to DOOR_OPEN and clear the bit.
    - Else if requests remain beyond nf in the travel direction: stay in the move state.
    - Else: go to IDLE.
  - The floor never moves below 0 or above NUM_FLOORS-1. A move only starts when a request exists in that direction.
- DOOR_OPEN:
  - The door counter increments each cycle. At DOOR_CYCLES-1, go to IDLE.
  - A request for `current_floor` arriving in this state is absorbed and restarts the door counter at 0, extending the open time.
  - Requests for other floors latch normally.
- Reversal only ever happens via IDLE. The car therefore passes through one IDLE cycle after the door closes before a new move starts.

## Timing
- Request latency: `req_valid` sampled at edge E0 makes `pending` visible after E0. The state leaves IDLE at E1.
- Travel time: for a target d floors away, the move starts at E1 and the car arrives at E1 + d·TRAVEL_CYCLES. `door_open` rises on that same edge, together with the final floor update.
- Door time: `door_open` stays high for exactly DOOR_CYCLES cycles, unless restarted by a current-floor request. `state` returns to IDLE on the following edge.
- Same-floor request from IDLE: door opens at E1 and `pending` clears at E1.
- Simultaneous events: on one edge, a clear (serve) and a set of a different bit both take effect. A set of the same bit is absorbed.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Parameters for all scenarios: NUM_FLOORS=10, TRAVEL_CYCLES=4, DOOR_CYCLES=3.
- Reset then idle:
  - Stimulus: assert reset for 2 cycles while driving `req_valid`=1 and `req_floor`=5.
  - Required: `current_floor`=0, `state`=00, `pending`=0, `dir_up`=1 throughout. Nothing is latched.
- Single request:
  - Stimulus: request floor 3 at E0.
  - Required: MOVE_UP at E1; floor reaches 1/2/3 at E5/E9/E13. `door_open`=1 for E13..E15, IDLE at E16, `pending`=0.
- SCAN order:
  - Stimulus: at floor 0, request 5; while the car passes floor 2, request 1 and 7.
  - Required: serves 5 then 7 (upward), then reverses and serves 1. `dir_up` falls only after the stop at 7.
- Door extension:
  - Stimulus: while the door is open at floor 3, assert a request for floor 3 in the second open cycle.
  - Required: `door_open` lasts 1+3 cycles and `pending[3]` stays 0.
- Boundaries:
  - Stimulus 1: request floor 12 (out of range).
  - Required 1: ignored.
  - Stimulus 2: requests for 9 then 0.
  - Required 2: the car never exceeds 9 or drops below 0; the door opens at both floors.
- Reset mid-move:
  - Stimulus: assert reset on the edge where the car is travelling up between floors 4 and 5 with `pending`={5,8}.
  - Required: next cycle shows floor 0, IDLE, `pending`=0.
